// File: rtl/y86_pkg.sv
// Shared Y86 pipeline encodings and the hazard-controller state type.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ctrl_state_e;

  // Instructions whose result arrives from memory and so cannot be forwarded from execute.
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage status in, stall/bubble controls and performance counters out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;
  logic             F_stall;
  logic             D_stall;
  logic             W_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             halted;
  logic [2:0]       halt_stat;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    input  halted, halt_stat, cycle_cnt, stall_cnt, bubble_cnt
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    output halted, halt_stat, cycle_cnt, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count register: clear wins over increment, saturation blocks the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline hazard controller: stall/bubble generation, halt tracking, perf counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_ctrl_if.slave   pif
);

  ctrl_state_e state_r;
  ctrl_state_e state_nxt_s;
  logic [2:0]  halt_stat_r;

  logic lu_s, rp_s, mp_s, ex_s, w_bad_s;
  logic f_stall_s, d_stall_s, w_stall_s;
  logic d_bubble_s, e_bubble_s, m_bubble_s, halted_s;
  logic run_s, any_bubble_s;

  // Hazard detection from the current stage contents.
  always_comb begin
    lu_s    = is_mem_load(pif.E_icode) && (pif.E_dstM != R_NONE) &&
              ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    rp_s    = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) || (pif.M_icode == I_RET);
    mp_s    = (pif.E_icode == I_JXX) && !pif.e_Cnd;
    w_bad_s = (pif.W_stat != S_AOK);
    ex_s    = (pif.m_stat != S_AOK) || w_bad_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a bad status reaching writeback stops the machine until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN:  begin
        if (w_bad_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Halt cause is latched on the same edge that enters HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_stat_r <= S_AOK;
    end else if ((state_r == ST_RUN) && w_bad_s) begin
      halt_stat_r <= pif.W_stat;
    end else begin
      halt_stat_r <= halt_stat_r;
    end
  end

  // Control outputs; a mispredict squashes decode, so it overrides a load-use stall there.
  always_comb begin
    f_stall_s  = 1'b0;
    d_stall_s  = 1'b0;
    w_stall_s  = 1'b0;
    d_bubble_s = 1'b0;
    e_bubble_s = 1'b0;
    m_bubble_s = 1'b0;
    halted_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        f_stall_s  = lu_s | rp_s;
        d_stall_s  = lu_s & ~mp_s;
        d_bubble_s = mp_s | (~lu_s & rp_s);
        e_bubble_s = mp_s | lu_s;
        m_bubble_s = ex_s;
        w_stall_s  = w_bad_s;
      end
      ST_HALT: begin
        f_stall_s = 1'b1;
        d_stall_s = 1'b1;
        w_stall_s = 1'b1;
        halted_s  = 1'b1;
      end
      default: begin
        halted_s = 1'b0;
      end
    endcase
  end

  assign pif.F_stall   = f_stall_s;
  assign pif.D_stall   = d_stall_s;
  assign pif.W_stall   = w_stall_s;
  assign pif.D_bubble  = d_bubble_s;
  assign pif.E_bubble  = e_bubble_s;
  assign pif.M_bubble  = m_bubble_s;
  assign pif.halted    = halted_s;
  assign pif.halt_stat = halt_stat_r;

  assign run_s        = (state_r == ST_RUN);
  assign any_bubble_s = d_bubble_s | e_bubble_s | m_bubble_s;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (run_s),
    .cnt   (pif.cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (run_s & f_stall_s),
    .cnt   (pif.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (run_s & any_bubble_s),
    .cnt   (pif.bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios plus randomized phases.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [3:0] NOP = 4'h1, MRM = 4'h5, JXX = 4'h7, RET = 4'h9, POP = 4'hB, RNO = 4'hF;
  localparam logic [2:0] AOK = 3'd1;

  typedef struct packed {
    logic             f_stall;
    logic             d_stall;
    logic             w_stall;
    logic             d_bubble;
    logic             e_bubble;
    logic             m_bubble;
    logic             halted;
    logic [2:0]       halt_stat;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] bub;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) pif ();
  pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .pif(pif));

  obs_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_cyc_seen = 0;

  // Reference model: the architectural effect of each cycle.
  bit         m_halted;
  logic [2:0] m_hstat;
  int         m_cyc, m_stl, m_bub;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected outputs for the inputs now on the bus, then advance the model by one edge.
  task automatic eval_push();
    obs_t e;
    bit lu, rp, mp, ex;
    lu = ((pif.E_icode == MRM) || (pif.E_icode == POP)) && (pif.E_dstM != RNO) &&
         ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    rp = (pif.D_icode == RET) || (pif.E_icode == RET) || (pif.M_icode == RET);
    mp = (pif.E_icode == JXX) && (pif.e_Cnd == 1'b0);
    ex = (pif.m_stat != AOK) || (pif.W_stat != AOK);
    e = '0;
    if (m_halted) begin
      e.f_stall = 1'b1; e.d_stall = 1'b1; e.w_stall = 1'b1;
    end else begin
      e.f_stall  = lu || rp;
      e.d_stall  = lu && !mp;
      e.d_bubble = mp || (!lu && rp);
      e.e_bubble = mp || lu;
      e.m_bubble = ex;
      e.w_stall  = (pif.W_stat != AOK);
    end
    e.halted    = m_halted;
    e.halt_stat = m_hstat;
    e.cyc = CNT_W'(m_cyc);
    e.stl = CNT_W'(m_stl);
    e.bub = CNT_W'(m_bub);
    sb.push_back(e);
    if (!m_halted) begin
      m_cyc = sat_inc(m_cyc);
      if (e.f_stall) m_stl = sat_inc(m_stl);
      if (e.d_bubble || e.e_bubble || e.m_bubble) m_bub = sat_inc(m_bub);
      if (pif.W_stat != AOK) begin
        m_halted = 1'b1;
        m_hstat  = pif.W_stat;
      end
    end
  endtask

  task automatic set_in(input logic [3:0] di, sa, sbr, ei, edm, input logic cnd,
                        input logic [3:0] mi, input logic [2:0] ms, ws);
    pif.D_icode = di; pif.d_srcA = sa; pif.d_srcB = sbr;
    pif.E_icode = ei; pif.E_dstM = edm; pif.e_Cnd = cnd;
    pif.M_icode = mi; pif.m_stat = ms; pif.W_stat = ws;
  endtask

  task automatic drive(input logic [3:0] di, sa, sbr, ei, edm, input logic cnd,
                       input logic [3:0] mi, input logic [2:0] ms, ws);
    @(posedge clk);
    #1;
    set_in(di, sa, sbr, ei, edm, cnd, mi, ms, ws);
    eval_push();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, AOK);
  endtask

  // Reset pulse placed mid-cycle; the first post-reset cycle is idle.
  task automatic do_reset();
    @(posedge clk);
    #2;
    set_in(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, AOK);
    rst_n = 1'b0;
    #1;
    check("rst_halted", 64'(pif.halted), 64'd0);
    check("rst_halt_stat", 64'(pif.halt_stat), 64'(AOK));
    check("rst_cycle_cnt", 64'(pif.cycle_cnt), 64'd0);
    check("rst_stall_cnt", 64'(pif.stall_cnt), 64'd0);
    check("rst_bubble_cnt", 64'(pif.bubble_cnt), 64'd0);
    #1;
    rst_n = 1'b1;
    m_halted = 1'b0; m_hstat = AOK; m_cyc = 0; m_stl = 0; m_bub = 0;
    eval_push();
  endtask

  function automatic logic [3:0] pick_icode();
    case ($urandom_range(0, 9))
      0, 1, 2: return NOP;
      3, 4:    return MRM;
      5:       return POP;
      6, 7:    return JXX;
      8:       return RET;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? RNO : 4'(r);
  endfunction

  function automatic logic [2:0] pick_stat(input int pct);
    if ($urandom_range(0, 99) < pct) return 3'($urandom_range(2, 4));
    return AOK;
  endfunction

  // Monitor: every falling edge with an outstanding expectation compares the full output set.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t exp_o, act_o;
      exp_o = sb.pop_front();
      act_o = {pif.F_stall, pif.D_stall, pif.W_stall, pif.D_bubble, pif.E_bubble,
               pif.M_bubble, pif.halted, pif.halt_stat, pif.cycle_cnt, pif.stall_cnt,
               pif.bubble_cnt};
      check($sformatf("outputs@%0d", n_cyc_seen), 64'(act_o), 64'(exp_o));
      n_cyc_seen++;
    end
  end

  initial begin
    set_in(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, AOK);
    do_reset();
    idle(2);
    // Load-use on srcA.
    drive(NOP, 4'h3, RNO, MRM, 4'h3, 1'b1, NOP, AOK, AOK);
    // Mispredict with E_dstM matching srcB.
    drive(NOP, RNO, 4'h2, JXX, 4'h2, 1'b0, NOP, AOK, AOK);
    // Return walking D, E, M.
    drive(RET, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, AOK);
    drive(NOP, RNO, RNO, RET, RNO, 1'b1, NOP, AOK, AOK);
    drive(NOP, RNO, RNO, NOP, RNO, 1'b1, RET, AOK, AOK);
    // Memory exception only, then a writeback fault that halts.
    drive(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, 3'd4, AOK);
    drive(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, 3'd3);
    drive(RET, 4'h1, 4'h1, POP, 4'h1, 1'b1, NOP, AOK, AOK);
    idle(3);
    do_reset();
    // Saturation: cycles, stalls and bubbles all pass the counter ceiling.
    for (int i = 0; i < CMAX + 4; i++) drive(RET, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, AOK);
    drive(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, 3'd2);
    idle(2);
    do_reset();
    // Randomized phases, each closed by a reset (often from HALT).
    for (int ph = 0; ph < 50; ph++) begin
      int len;
      len = $urandom_range(6, 14);
      for (int c = 0; c < len; c++) begin
        logic [3:0] ei, edm;
        ei  = pick_icode();
        edm = ($urandom_range(0, 1) == 0) ? pick_reg() : 4'($urandom_range(0, 15));
        drive(pick_icode(), pick_reg(), pick_reg(), ei, edm, 1'($urandom_range(0, 1)),
              pick_icode(), pick_stat(10), pick_stat(6));
      end
      do_reset();
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
